// File: rtl/pc_unit.sv
// pc_unit: program counter with EXC > STALL > SEL priority and an optional return-address stack.
// Build option: define PC_UNIT_RAS_EN to include the circular return-address stack.
module pc_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              STALL,
  input  logic              EXC,
  input  logic [2:0]        SEL,
  input  logic [ADDR_W-1:0] BRANCH_ADDR,
  input  logic [ADDR_W-1:0] JUMP_ADDR,
  output logic [ADDR_W-1:0] O_inst_addr,
  output logic              RAS_EMPTY,
  output logic              RAS_FULL,
  output logic              RAS_OVF,
  output logic              RAS_UNF
);

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_CALL   = 3'd3;
  localparam logic [2:0] SEL_RET    = 3'd4;

  generate
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
      $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc      = pc_reg + ADDR_W'(1);
  assign O_inst_addr = pc_reg;

`ifdef PC_UNIT_RAS_EN
  localparam int             PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W:0]    cnt_reg;
  logic              ovf_reg;
  logic              unf_reg;
  logic              push;
  logic              pop;
  logic              unf_set;

  // ptr_reg is the next free slot; when full it also points at the oldest entry
  assign top_idx = ptr_reg - PTR_W'(1);

  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_entry
      logic [ADDR_W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && !rst && ptr_reg == PTR_W'(gi)) begin
          entry_reg <= pc_inc;
        end
      end
      assign ras_mem[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (push) begin
        ptr_reg <= ptr_reg + PTR_W'(1);
        if (cnt_reg == CNT_FULL) begin
          ovf_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + (PTR_W + 1)'(1);
        end
      end else if (pop) begin
        ptr_reg <= top_idx;
        cnt_reg <= cnt_reg - (PTR_W + 1)'(1);
      end
      if (unf_set) begin
        unf_reg <= 1'b1;
      end
    end
  end

  assign RAS_EMPTY = (cnt_reg == '0);
  assign RAS_FULL  = (cnt_reg == CNT_FULL);
  assign RAS_OVF   = ovf_reg;
  assign RAS_UNF   = unf_reg;
`else
  assign RAS_EMPTY = 1'b1;
  assign RAS_FULL  = 1'b0;
  assign RAS_OVF   = 1'b0;
  assign RAS_UNF   = 1'b0;
`endif

  always_comb begin
    pc_next = pc_reg;
`ifdef PC_UNIT_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    unf_set = 1'b0;
`endif
    if (EXC) begin
      pc_next = EXC_VEC;
    end else if (!STALL) begin
      case (SEL)
        SEL_SEQ:    pc_next = pc_inc;
        SEL_BRANCH: pc_next = BRANCH_ADDR;
        SEL_JUMP:   pc_next = JUMP_ADDR;
        SEL_CALL: begin
          pc_next = JUMP_ADDR;
`ifdef PC_UNIT_RAS_EN
          push    = 1'b1;
`endif
        end
        SEL_RET: begin
`ifdef PC_UNIT_RAS_EN
          if (cnt_reg != '0) begin
            pc_next = ras_mem[top_idx];
            pop     = 1'b1;
          end else begin
            pc_next = pc_inc;
            unf_set = 1'b1;
          end
`else
          pc_next = pc_inc;
`endif
        end
        default:    pc_next = pc_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_VEC;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors plus randomized stimulus against a queue-based reference model.
// Adapts its expectations to whether PC_UNIT_RAS_EN is defined for the build.
module tb_pc_unit;
  localparam int DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       STALL;
  logic       EXC;
  logic [2:0] SEL;
  logic [7:0] BRANCH_ADDR;
  logic [7:0] JUMP_ADDR;
  logic [7:0] O_inst_addr;
  logic       RAS_EMPTY;
  logic       RAS_FULL;
  logic       RAS_OVF;
  logic       RAS_UNF;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // reference model: PC value, stack as a queue (back = top), sticky flags
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;

  pc_unit dut (
    .clk(clk), .rst(rst), .STALL(STALL), .EXC(EXC), .SEL(SEL),
    .BRANCH_ADDR(BRANCH_ADDR), .JUMP_ADDR(JUMP_ADDR), .O_inst_addr(O_inst_addr),
    .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL), .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_edge(input logic st, input logic ex, input logic [2:0] sl,
                                     input logic [7:0] br, input logic [7:0] jp);
    logic [7:0] nxt;
    nxt = m_pc + 8'd1;
    if (ex) m_pc = 8'hFF;
    else if (!st) begin
      case (sl)
        3'd0: m_pc = nxt;
        3'd1: m_pc = br;
        3'd2: m_pc = jp;
        3'd3: begin
          if (RAS_ON) begin
            if (m_stk.size() == DEPTH) begin
              void'(m_stk.pop_front());
              m_ovf = 1'b1;
            end
            m_stk.push_back(nxt);
          end
          m_pc = jp;
        end
        3'd4: begin
          if (RAS_ON && m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc = nxt;
            if (RAS_ON) m_unf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_pc"},    O_inst_addr, m_pc);
    check({tag, "_empty"}, RAS_EMPTY,   RAS_ON ? (m_stk.size() == 0) : 1'b1);
    check({tag, "_full"},  RAS_FULL,    RAS_ON ? (m_stk.size() == DEPTH) : 1'b0);
    check({tag, "_ovf"},   RAS_OVF,     m_ovf);
    check({tag, "_unf"},   RAS_UNF,     m_unf);
  endtask

  task automatic step(input string tag, input logic st, input logic ex, input logic [2:0] sl,
                      input logic [7:0] br, input logic [7:0] jp);
    STALL = st; EXC = ex; SEL = sl; BRANCH_ADDR = br; JUMP_ADDR = jp;
    @(posedge clk);
    model_edge(st, ex, sl, br, jp);
    #1;
    txn++;
    $display("txn %0d %s stall=%0b exc=%0b sel=%0d br=%02h jp=%02h -> pc=%02h", txn, tag, st, ex, sl,
             br, jp, O_inst_addr);
    check_state(tag);
  endtask

  // reset asserted and released between edges
  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    model_reset();
    txn++;
    $display("txn %0d rst_pulse -> pc=%02h", txn, O_inst_addr);
    check_state("rst_async");
    rst = 1'b0;
    #1;
  endtask

  // reset held across an edge while a call is requested: the call must be discarded
  task automatic rst_over_call();
    SEL = 3'd3; JUMP_ADDR = 8'hA5; STALL = 1'b0; EXC = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    txn++;
    $display("txn %0d rst_over_call -> pc=%02h", txn, O_inst_addr);
    check_state("rst_call");
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; STALL = 1'b0; EXC = 1'b0; SEL = 3'd0; BRANCH_ADDR = 8'h00; JUMP_ADDR = 8'h00;
    #2;
    model_reset();
    check_state("reset");
    #10;
    check_state("reset_hold");
    rst = 1'b0;

    // async reset then three sequential edges
    step("seq", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step("seq", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    rst_pulse();
    check("r033_rst", O_inst_addr, 8'h00);
    step("seq", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("r033_1", O_inst_addr, 8'h01);
    step("seq", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("r033_2", O_inst_addr, 8'h02);
    step("seq", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("r033_3", O_inst_addr, 8'h03);

    // call then return
    step("jump", 1'b0, 1'b0, 3'd2, 8'h00, 8'h10);
    step("call", 1'b0, 1'b0, 3'd3, 8'h00, 8'h40);
    check("r034_call", O_inst_addr, 8'h40);
    step("ret", 1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
    check("r034_ret", O_inst_addr, RAS_ON ? 8'h11 : 8'h41);
    check("r034_empty", RAS_EMPTY, 1'b1);

    // overflow: five calls then four returns
    rst_pulse();
    step("call", 1'b0, 1'b0, 3'd3, 8'h00, 8'h20);
    step("call", 1'b0, 1'b0, 3'd3, 8'h00, 8'h30);
    step("call", 1'b0, 1'b0, 3'd3, 8'h00, 8'h40);
    step("call", 1'b0, 1'b0, 3'd3, 8'h00, 8'h50);
    step("call", 1'b0, 1'b0, 3'd3, 8'h00, 8'h60);
    check("r035_full", RAS_FULL, RAS_ON);
    check("r035_ovf", RAS_OVF, RAS_ON);
    step("ret", 1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
`ifdef PC_UNIT_RAS_EN
    check("r035_ret1", O_inst_addr, 8'h51);
`endif
    step("ret", 1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
`ifdef PC_UNIT_RAS_EN
    check("r035_ret2", O_inst_addr, 8'h41);
`endif
    step("ret", 1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
`ifdef PC_UNIT_RAS_EN
    check("r035_ret3", O_inst_addr, 8'h31);
`endif
    step("ret", 1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
`ifdef PC_UNIT_RAS_EN
    check("r035_ret4", O_inst_addr, 8'h21);
`endif

    // underflow on empty stack, flag sticky
    rst_pulse();
    step("jump", 1'b0, 1'b0, 3'd2, 8'h00, 8'h33);
    step("ret", 1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
    check("r036_pc", O_inst_addr, 8'h34);
    check("r036_unf", RAS_UNF, RAS_ON);
    for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("r036_sticky", RAS_UNF, RAS_ON);

    // stall holds, exception beats stall, wrap
    step("call", 1'b0, 1'b0, 3'd3, 8'h00, 8'h70);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 3'd3, 8'h00, 8'h99);
    check("r037_hold", O_inst_addr, 8'h70);
    step("exc", 1'b1, 1'b1, 3'd3, 8'h00, 8'h99);
    check("r037_exc", O_inst_addr, 8'hFF);
    step("seq", 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("r038_wrap", O_inst_addr, 8'h00);
    step("hold", 1'b0, 1'b0, 3'd6, 8'h12, 8'h34);

    rst_over_call();

    // randomized stimulus, biased toward call/return traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) rst_pulse();
      else if (r < 4) rst_over_call();
      else begin
        logic [2:0] sl;
        logic st, ex;
        sl = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(3, 4));
        st = ($urandom_range(0, 7) == 0);
        ex = ($urandom_range(0, 19) == 0);
        step("rand", st, ex, sl, 8'($urandom), 8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 8, program counter and address width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two and at least 2.
REQ-003 Parameter RESET_VEC, default 0, PC value loaded by reset.
REQ-004 Parameter EXC_VEC, default all-ones of ADDR_W, PC value loaded on exception.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 STALL  input  1  hold request.
REQ-008 EXC  input  1  exception redirect request.
REQ-009 SEL  input  3  next-PC select: 000 seq, 001 branch, 010 jump, 011 call, 100 return, 101-111 hold.
REQ-010 BRANCH_ADDR  input  ADDR_W  branch target.
REQ-011 JUMP_ADDR  input  ADDR_W  jump and call target.
REQ-012 O_inst_addr  output  ADDR_W  current PC, driven directly from the PC register.
REQ-013 RAS_EMPTY, RAS_FULL  output  1 each  stack occupancy is 0, stack occupancy is RAS_DEPTH.
REQ-014 RAS_OVF, RAS_UNF  output  1 each  sticky flags for stack overflow and underflow.

Function
REQ-015 PC priority per edge SHALL be: EXC, then STALL, then SEL.
REQ-016 EXC=1 SHALL load EXC_VEC regardless of STALL and SEL; stack and flags unchanged.
REQ-017 STALL=1 with EXC=0 SHALL hold PC, stack contents, pointer, count and flags.
REQ-018 seq SHALL load PC+1 modulo 2^ADDR_W; 0xFF wraps to 0x00 at ADDR_W=8.
REQ-019 branch SHALL load BRANCH_ADDR; jump SHALL load JUMP_ADDR.
REQ-020 SEL 101-111 SHALL hold PC.
REQ-021 call SHALL load JUMP_ADDR and push PC+1 (modulo 2^ADDR_W) in the same edge.
REQ-022 return with count>0 SHALL load the top entry and pop it in the same edge; latency is one edge.
REQ-023 Stack SHALL be circular, with a ADDR_W-by-RAS_DEPTH register file, a log2(RAS_DEPTH)-bit top pointer and a count that saturates at RAS_DEPTH.
REQ-024 Push when full SHALL overwrite the oldest entry, keep count=RAS_DEPTH and set RAS_OVF.
REQ-025 Return when empty SHALL load PC+1, leave the pointer and count unchanged and set RAS_UNF.
REQ-026 RAS_OVF and RAS_UNF SHALL clear only on rst.
REQ-027 RAS_EMPTY and RAS_FULL SHALL be combinational decodes of the registered count.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, set O_inst_addr=RESET_VEC, pointer=0, count=0, RAS_EMPTY=1, RAS_FULL=0, RAS_OVF=0 and RAS_UNF=0.
REQ-029 Stack entry contents are not reset and SHALL NOT be observable until pushed.
REQ-030 rst asserted mid-call or mid-return SHALL discard that update; the first edge after deassertion follows REQ-015.

Configuration
REQ-031 Macro PC_UNIT_RAS_EN SHALL control the stack; when it is defined, REQ-021 to REQ-027 apply.
REQ-032 Without PC_UNIT_RAS_EN: no stack storage; call SHALL behave as jump; return SHALL load PC+1; RAS_EMPTY is tied to 1; RAS_FULL, RAS_OVF and RAS_UNF are tied to 0.

Verification (defaults, PC_UNIT_RAS_EN defined)
REQ-033 rst pulse between edges -> O_inst_addr=0x00 before the next edge; then 3 seq edges -> 0x01, 0x02, 0x03.
REQ-034 PC=0x10, call with JUMP_ADDR=0x40 -> PC=0x40; then return -> PC=0x11 and RAS_EMPTY=1.
REQ-035 5 calls from PCs 0x00, 0x20, 0x30, 0x40, 0x50 -> RAS_FULL=1 and RAS_OVF=1; then 4 returns -> 0x51, 0x41, 0x31, 0x21.
REQ-036 Return with an empty stack at PC=0x33 -> PC=0x34 and RAS_UNF=1, which persists until rst.
REQ-037 STALL=1 with SEL=call for 3 edges -> PC and count unchanged; then EXC=1 with STALL=1 -> PC=0xFF.
REQ-038 PC=0xFF with seq -> PC=0x00; rebuild without PC_UNIT_RAS_EN, call 0x40 then return -> PC=0x41.
